// File: rtl/regfile_multiport_if.sv
// regfile_multiport_if: read, write, issue and status signals of the
// multiport register file, bundled with master/slave views.
interface regfile_multiport_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_pending;
  logic                we0;
  logic [AW-1:0]       wa0;
  logic [XLEN-1:0]     wd0;
  logic                we1;
  logic [AW-1:0]       wa1;
  logic [XLEN-1:0]     wd1;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                ready;

  modport master (
    output rd_addr, we0, wa0, wd0, we1, wa1, wd1, iss_valid, iss_rd,
    input  rd_data, rd_pending, ready
  );

  modport slave (
    input  rd_addr, we0, wa0, wd0, we1, wa1, wd1, iss_valid, iss_rd,
    output rd_data, rd_pending, ready
  );
endinterface

// File: rtl/regfile_multiport.sv
// regfile_multiport: NRD combinational read ports, two write ports (ALU and
// load writeback), x0 hardwired to zero, optional same-cycle forwarding, a
// per-register pending scoreboard and a post-reset sweep loading regs[i] = i.
module regfile_multiport #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input logic                clk,
  input logic                rst,
  regfile_multiport_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  localparam logic [0:0]    ST_INIT  = 1'b0;
  localparam logic [0:0]    ST_RUN   = 1'b1;
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  logic [0:0]       state;
  logic [AW-1:0]    init_idx;
  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pending;
  logic [AW-1:0]    ra [NRD];
  logic             run;
  logic             wr0;
  logic             wr1;
  logic             iss;

  // External writes and issues only count once the sweep is done; x0 is never a target.
  assign run = (state == ST_RUN);
  assign wr0 = run && bus.we0 && (bus.wa0 != '0);
  assign wr1 = run && bus.we1 && (bus.wa1 != '0);
  assign iss = run && bus.iss_valid && (bus.iss_rd != '0);
  assign bus.ready = run;

  // Sweep controller: one register per cycle after reset, then park in RUN without wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_INIT;
      init_idx <= '0;
    end else if (state == ST_INIT) begin
      if (init_idx == LAST_IDX) begin
        state <= ST_RUN;
      end else begin
        init_idx <= init_idx + 1'b1;
      end
    end
  end

  // Register array: sweep value during INIT, then the two write ports with port 1 last.
  // NOTE: the array deliberately has no reset; the INIT sweep defines every entry, so it maps onto plain storage.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      regs[init_idx] <= XLEN'(init_idx);
    end else begin
      if (wr0) regs[bus.wa0] <= bus.wd0;
      if (wr1) regs[bus.wa1] <= bus.wd1;
    end
  end

  // Scoreboard: writebacks clear, issues set; the set is written last so it wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      // NOTE: several non-blocking assignments to the same bit in one block resolve to the last one executed.
      if (wr0) pending[bus.wa0]    <= 1'b0;
      if (wr1) pending[bus.wa1]    <= 1'b0;
      if (iss) pending[bus.iss_rd] <= 1'b1;
    end
  end

  // Unpack the flat read-address bus into one address per port.
  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      ra[k] = bus.rd_addr[k*AW +: AW];
    end
  end

  // Read ports: zero outside RUN and for x0, otherwise forwarded write data or stored value.
  always_comb begin
    bus.rd_data    = '0;
    bus.rd_pending = '0;
    for (int k = 0; k < NRD; k++) begin
      bus.rd_pending[k] = pending[ra[k]];
      if (run && (ra[k] != '0)) begin
        if ((BYPASS != 0) && wr1 && (bus.wa1 == ra[k])) begin
          bus.rd_data[k*XLEN +: XLEN] = bus.wd1;
        end else if ((BYPASS != 0) && wr0 && (bus.wa0 == ra[k])) begin
          bus.rd_data[k*XLEN +: XLEN] = bus.wd0;
        end else begin
          bus.rd_data[k*XLEN +: XLEN] = regs[ra[k]];
        end
      end
    end
  end
endmodule
